// File: rtl/boa_xm_pkg.sv
// Shared types for the slow external-memory responders: FSM states,
// half-select encoding and wait-counter width.
package boa_xm_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ADDR = 3'd1,
    STB  = 3'd2,
    HOLD = 3'd3,
    DONE = 3'd4
  } state_e;

  localparam logic HALF_LO = 1'b0;
  localparam logic HALF_HI = 1'b1;
  localparam int   WAIT_W  = 4;

  // Byte enables belonging to one 16-bit half of the word.
  function automatic logic [1:0] half_be(input logic [3:0] be, input logic half);
    return (half == HALF_HI) ? be[3:2] : be[1:0];
  endfunction

endpackage

// File: rtl/boa_xm_sram_ctrl_if.sv
// Word request/response bus between the cache's external port and the responder.
// Handshake: the master holds re/we/addr/wdata stable until bus_ready pulses for one cycle.
interface boa_xm_bus_if #(
  parameter int alen = 24
);
  logic              bus_re;
  logic [3:0]        bus_we;
  logic [alen-3:0]   bus_addr;
  logic [31:0]       bus_wdata;
  logic              bus_ready;
  logic [31:0]       bus_rdata;

  modport master (
    output bus_re, bus_we, bus_addr, bus_wdata,
    input  bus_ready, bus_rdata
  );

  modport slave (
    input  bus_re, bus_we, bus_addr, bus_wdata,
    output bus_ready, bus_rdata
  );
endinterface

// File: rtl/boa_xm_wait_timer.sv
// Loadable down-counter for strobe wait states; last is high once the count reaches zero.
module boa_xm_wait_timer
  import boa_xm_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              dec,
  input  logic [WAIT_W-1:0] load_val,
  output logic              last
);

  logic [WAIT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load)
      cnt_d = load_val;
    else if (dec && (cnt_q != '0))
      cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

  assign last = (cnt_q == '0);

endmodule

// File: rtl/boa_xm_sram_ctrl.sv
// Answers 32-bit word reads/writes as two 16-bit accesses to an asynchronous
// SRAM/PSRAM, with wait_cycles extra strobe cycles per half.
module boa_xm_sram_ctrl
  import boa_xm_pkg::*;
#(
  parameter int alen        = 24,
  parameter int wait_cycles = 1,
  parameter int sram_awidth = alen - 1
) (
  input  logic                   clk,
  input  logic                   rst,
  boa_xm_bus_if.slave            bus,
  output logic [sram_awidth-1:0] sram_addr,
  output logic [15:0]            sram_dq_o,
  output logic                   sram_dq_oe,
  input  logic [15:0]            sram_dq_i,
  output logic                   sram_ce_n,
  output logic                   sram_oe_n,
  output logic                   sram_we_n,
  output logic                   sram_ub_n,
  output logic                   sram_lb_n,
  output state_e                 dbg_state
);

  state_e          state_q, state_d;
  logic            half_q, half_d;
  logic            is_wr_q, is_wr_d;
  logic [3:0]      be_q, be_d;
  logic [alen-3:0] addr_q, addr_d;
  logic [31:0]     wdata_q, wdata_d;
  logic [15:0]     lo_q, lo_d;
  logic [31:0]     rdata_q, rdata_d;
  logic            tmr_load, tmr_dec, tmr_last;
  logic [1:0]      cur_be;

  boa_xm_wait_timer u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .dec      (tmr_dec),
    .load_val (WAIT_W'(wait_cycles)),
    .last     (tmr_last)
  );

  always_comb begin
    state_d  = state_q;
    half_d   = half_q;
    is_wr_d  = is_wr_q;
    be_d     = be_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    lo_d     = lo_q;
    rdata_d  = rdata_q;
    tmr_load = 1'b0;
    tmr_dec  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.bus_re || (bus.bus_we != 4'b0000)) begin
          addr_d  = bus.bus_addr;
          wdata_d = bus.bus_wdata;
          be_d    = bus.bus_we;
          is_wr_d = (bus.bus_we != 4'b0000);
          rdata_d = '0;
          // A write with no low-half lanes starts directly on the high half.
          half_d  = ((bus.bus_we != 4'b0000) && (bus.bus_we[1:0] == 2'b00)) ? HALF_HI : HALF_LO;
          state_d = ADDR;
        end
      end
      ADDR: begin
        tmr_load = 1'b1;
        state_d  = STB;
      end
      STB: begin
        tmr_dec = 1'b1;
        if (tmr_last) begin
          if (is_wr_q) begin
            state_d = HOLD;
          end else if (half_q == HALF_LO) begin
            lo_d    = sram_dq_i;
            half_d  = HALF_HI;
            state_d = ADDR;
          end else begin
            rdata_d = {sram_dq_i, lo_q};
            state_d = DONE;
          end
        end
      end
      HOLD: begin
        if ((half_q == HALF_LO) && (be_q[3:2] != 2'b00)) begin
          half_d  = HALF_HI;
          state_d = ADDR;
        end else begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      half_q  <= HALF_LO;
      is_wr_q <= 1'b0;
      be_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      lo_q    <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      half_q  <= half_d;
      is_wr_q <= is_wr_d;
      be_q    <= be_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      lo_q    <= lo_d;
      rdata_q <= rdata_d;
    end
  end

  assign cur_be = half_be(be_q, half_q);

  // Reads never drive the data bus, so dq_oe cannot overlap oe_n=0.
  always_comb begin
    sram_ce_n  = 1'b1;
    sram_oe_n  = 1'b1;
    sram_we_n  = 1'b1;
    sram_ub_n  = 1'b1;
    sram_lb_n  = 1'b1;
    sram_dq_oe = 1'b0;
    case (state_q)
      ADDR: begin
        sram_ce_n  = 1'b0;
        sram_dq_oe = is_wr_q;
      end
      STB: begin
        sram_ce_n = 1'b0;
        if (is_wr_q) begin
          sram_we_n  = 1'b0;
          sram_ub_n  = ~cur_be[1];
          sram_lb_n  = ~cur_be[0];
          sram_dq_oe = 1'b1;
        end else begin
          sram_oe_n = 1'b0;
          sram_ub_n = 1'b0;
          sram_lb_n = 1'b0;
        end
      end
      HOLD: begin
        sram_ce_n  = 1'b0;
        sram_ub_n  = ~cur_be[1];
        sram_lb_n  = ~cur_be[0];
        sram_dq_oe = 1'b1;
      end
      default: ;
    endcase
  end

  assign sram_addr     = sram_awidth'({addr_q, half_q});
  assign sram_dq_o     = is_wr_q ? ((half_q == HALF_HI) ? wdata_q[31:16] : wdata_q[15:0]) : 16'h0000;
  assign bus.bus_ready = (state_q == DONE);
  assign bus.bus_rdata = (state_q == DONE) ? rdata_q : 32'h0;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_boa_xm_sram_ctrl.sv
// Directed bench: one responder with wait_cycles=1 and one with wait_cycles=0
// share a behavioural 16-bit SRAM; sel picks which one is being exercised.
module tb_boa_xm_sram_ctrl;
  import boa_xm_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic sel = 1'b1;
  always #5 clk = ~clk;

  logic        t_re   = 1'b0;
  logic [3:0]  t_we   = 4'b0;
  logic [21:0] t_addr = '0;
  logic [31:0] t_wd   = '0;

  boa_xm_bus_if #(.alen(24)) if1 ();
  boa_xm_bus_if #(.alen(24)) if0 ();

  assign if1.bus_re    = sel ? t_re : 1'b0;
  assign if1.bus_we    = sel ? t_we : 4'b0;
  assign if1.bus_addr  = t_addr;
  assign if1.bus_wdata = t_wd;
  assign if0.bus_re    = sel ? 1'b0 : t_re;
  assign if0.bus_we    = sel ? 4'b0 : t_we;
  assign if0.bus_addr  = t_addr;
  assign if0.bus_wdata = t_wd;

  logic [22:0] a1, a0;
  logic [15:0] dqo1, dqo0, dq_i;
  logic        oe1, oe0, ce1, ce0, rd1, rd0, wr1, wr0, ub1, ub0, lb1, lb0;
  state_e      st1, st0;

  boa_xm_sram_ctrl #(.alen(24), .wait_cycles(1)) u_dut (
    .clk(clk), .rst(rst), .bus(if1.slave),
    .sram_addr(a1), .sram_dq_o(dqo1), .sram_dq_oe(oe1), .sram_dq_i(dq_i),
    .sram_ce_n(ce1), .sram_oe_n(rd1), .sram_we_n(wr1), .sram_ub_n(ub1), .sram_lb_n(lb1),
    .dbg_state(st1)
  );

  boa_xm_sram_ctrl #(.alen(24), .wait_cycles(0)) u_dut0 (
    .clk(clk), .rst(rst), .bus(if0.slave),
    .sram_addr(a0), .sram_dq_o(dqo0), .sram_dq_oe(oe0), .sram_dq_i(dq_i),
    .sram_ce_n(ce0), .sram_oe_n(rd0), .sram_we_n(wr0), .sram_ub_n(ub0), .sram_lb_n(lb0),
    .dbg_state(st0)
  );

  wire [22:0] m_addr  = sel ? a1 : a0;
  wire [15:0] m_dqo   = sel ? dqo1 : dqo0;
  wire        m_dq_oe = sel ? oe1 : oe0;
  wire        m_ce_n  = sel ? ce1 : ce0;
  wire        m_oe_n  = sel ? rd1 : rd0;
  wire        m_we_n  = sel ? wr1 : wr0;
  wire        m_ub_n  = sel ? ub1 : ub0;
  wire        m_lb_n  = sel ? lb1 : lb0;
  wire        m_ready = sel ? if1.bus_ready : if0.bus_ready;
  wire [31:0] m_rdata = sel ? if1.bus_rdata : if0.bus_rdata;
  wire state_e m_state = sel ? st1 : st0;

  // SRAM model: async read, byte-lane write while ce_n and we_n are low.
  logic [15:0] mem [0:1023];
  logic        pk_en = 1'b0;
  logic [9:0]  pk_a  = '0;
  logic [15:0] pk_d  = '0;

  assign dq_i = (!m_ce_n && !m_oe_n) ? mem[m_addr[9:0]] : 16'h0000;

  always @(posedge clk) begin
    if (pk_en) mem[pk_a] <= pk_d;
    else if (!m_ce_n && !m_we_n) begin
      if (!m_lb_n) mem[m_addr[9:0]][7:0]  <= m_dqo[7:0];
      if (!m_ub_n) mem[m_addr[9:0]][15:8] <= m_dqo[15:8];
    end
  end

  // Strobe log: start address/lanes and length of each oe_n/we_n low run.
  logic [22:0] addr_log[$];
  logic [1:0]  lane_log[$];
  int          run_log[$];
  int          run_len   = 0;
  logic        prev_on   = 1'b0;
  int          oe_cnt    = 0;
  int          conflicts = 0;
  wire         strobe_on = !m_oe_n || !m_we_n;

  always @(negedge clk) begin
    if (strobe_on && !prev_on) begin
      addr_log.push_back(m_addr);
      lane_log.push_back({m_ub_n, m_lb_n});
    end
    if (!strobe_on && prev_on) run_log.push_back(run_len);
    run_len <= (strobe_on && !prev_on) ? 1 : run_len + 1;
    prev_on <= strobe_on;
    if (m_dq_oe) oe_cnt <= oe_cnt + 1;
    if (m_dq_oe && !m_oe_n) conflicts <= conflicts + 1;
  end

  logic [31:0] exp_q[$];
  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_tests++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  task automatic poke(input logic [9:0] a, input logic [15:0] d);
    @(negedge clk);
    pk_a = a; pk_d = d; pk_en = 1'b1;
    @(negedge clk);
    pk_en = 1'b0;
  endtask

  task automatic drive_req(input logic re, input logic [3:0] we, input logic [21:0] addr,
                           input logic [31:0] wd, input logic [31:0] exp_rd, input bit push);
    int guard;
    guard = 0;
    @(negedge clk);
    while (m_state != IDLE && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    t_re = re; t_we = we; t_addr = addr; t_wd = wd;
    if (push) exp_q.push_back(exp_rd);
  endtask

  task automatic wait_ready(input string tag, input int exp_lat);
    int   n;
    logic [31:0] e;
    n = 0;
    @(posedge clk);
    for (int i = 1; i <= 64; i++) begin
      #1;
      if (m_ready) begin
        n = i;
        break;
      end
      @(posedge clk);
    end
    if (exp_lat > 0) chk({tag, "_latency"}, n, exp_lat);
    else             chk({tag, "_ready_seen"}, 32'(n != 0), 32'd1);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hFFFF_FFFF;
    chk({tag, "_rdata"}, m_rdata, e);
  endtask

  task automatic idle_bus();
    t_re = 1'b0; t_we = 4'b0;
  endtask

  int base_a, base_r, oe_before, guard;

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 16'h0000;
    rst = 1'b0;
    poke(10'h200, 16'hBEEF);
    poke(10'h201, 16'hDEAD);
    poke(10'h060, 16'h2222);
    poke(10'h061, 16'h1111);
    poke(10'h080, 16'h5500);
    poke(10'h000, 16'h0A0B);
    poke(10'h001, 16'h0C0D);
    poke(10'h002, 16'h1A2B);
    poke(10'h003, 16'h3C4D);

    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      #1;
      chk("rst_ready", 32'(m_ready), 32'd0);
      chk("rst_rdata", m_rdata, 32'h0);
      chk("rst_strobes", 32'({m_ce_n, m_oe_n, m_we_n, m_ub_n, m_lb_n}), 32'h1F);
      chk("rst_dq_oe", 32'(m_dq_oe), 32'd0);
      chk("rst_addr", 32'(m_addr), 32'h0);
      chk("rst_dq_o", 32'(m_dqo), 32'h0);
    end
    sel = 1'b1;
    @(negedge clk);
    rst = 1'b1;

    // Word read, wait_cycles=1.
    base_a = addr_log.size(); base_r = run_log.size(); oe_before = oe_cnt;
    drive_req(1'b1, 4'b0000, 22'h000100, 32'h0, 32'hDEADBEEF, 1'b1);
    wait_ready("rd1", 7);
    idle_bus();
    chk("rd1_dq_oe_quiet", 32'(oe_cnt - oe_before), 32'd0);
    chk("rd1_addr_lo", 32'(addr_log[base_a]), 32'h200);
    chk("rd1_addr_hi", 32'(addr_log[base_a+1]), 32'h201);
    chk("rd1_run_lo", 32'(run_log[base_r]), 32'd2);

    // Full-word write.
    base_a = addr_log.size(); base_r = run_log.size();
    drive_req(1'b0, 4'b1111, 22'h000010, 32'h12345678, 32'h0, 1'b1);
    wait_ready("wr_full", 9);
    idle_bus();
    @(negedge clk);
    chk("wr_full_mem_lo", 32'(mem[10'h020]), 32'h5678);
    chk("wr_full_mem_hi", 32'(mem[10'h021]), 32'h1234);
    chk("wr_full_we_run_lo", 32'(run_log[base_r]), 32'd2);
    chk("wr_full_we_run_hi", 32'(run_log[base_r+1]), 32'd2);
    chk("wr_full_addr_hi", 32'(addr_log[base_a+1]), 32'h021);

    // Single byte in the high half: low half skipped.
    base_a = addr_log.size();
    drive_req(1'b0, 4'b0100, 22'h000030, 32'hAABBCCDD, 32'h0, 1'b1);
    wait_ready("wr_skip", 5);
    idle_bus();
    @(negedge clk);
    chk("wr_skip_halves", 32'(addr_log.size() - base_a), 32'd1);
    chk("wr_skip_addr", 32'(addr_log[base_a]), 32'h061);
    chk("wr_skip_lanes", 32'(lane_log[base_a]), 32'b10);
    chk("wr_skip_mem_hi", 32'(mem[10'h061]), 32'h11BB);
    chk("wr_skip_mem_lo", 32'(mem[10'h060]), 32'h2222);

    // re together with we: a write; request held through DONE is taken again.
    drive_req(1'b1, 4'b0001, 22'h000040, 32'h000000EE, 32'h0, 1'b1);
    wait_ready("rw", 5);
    @(posedge clk); #1;
    chk("rw_idle_after_done", 32'(m_state), 32'(IDLE));
    @(posedge clk); #1;
    chk("rw_reaccept", 32'(m_state), 32'(ADDR));
    idle_bus();
    exp_q.push_back(32'h0);
    wait_ready("rw_again", -1);
    @(negedge clk);
    chk("rw_mem", 32'(mem[10'h080]), 32'h55EE);

    // Reset in the middle of a write strobe.
    drive_req(1'b0, 4'b1111, 22'h000050, 32'hCAFEF00D, 32'h0, 1'b0);
    guard = 0;
    @(negedge clk);
    while (m_we_n && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    chk("abort_reached_stb", 32'(m_we_n), 32'd0);
    rst = 1'b0;
    idle_bus();
    @(posedge clk); #1;
    chk("abort_strobes", 32'({m_ce_n, m_we_n, m_dq_oe}), 32'b110);
    chk("abort_no_ready", 32'(m_ready), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("abort_quiet", 32'(m_ready), 32'd0);
    end
    @(negedge clk);
    rst = 1'b1;
    drive_req(1'b1, 4'b0000, 22'h000100, 32'h0, 32'hDEADBEEF, 1'b1);
    wait_ready("rd_after_rst", 7);
    idle_bus();

    // wait_cycles=0 back-to-back reads.
    @(negedge clk);
    sel = 1'b0;
    base_a = addr_log.size();
    drive_req(1'b1, 4'b0000, 22'h000000, 32'h0, 32'h0C0D0A0B, 1'b1);
    wait_ready("w0_rd0", 5);
    idle_bus();
    drive_req(1'b1, 4'b0000, 22'h000001, 32'h0, 32'h3C4D1A2B, 1'b1);
    wait_ready("w0_rd1", 5);
    idle_bus();
    @(negedge clk);
    for (int i = 0; i < 4; i++)
      chk("w0_addr_seq", 32'(addr_log[base_a+i]), 32'(i));

    chk("dq_oe_vs_oe_n", 32'(conflicts), 32'd0);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
